// File: rtl/glyph_stream.sv
// Writable-font glyph renderer: streams one pixel per handshake in raster order,
// with integer upscaling and per-request inversion.
module glyph_stream #(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 8,
  parameter int unsigned CODE_W  = 8,
  parameter int unsigned SCALE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [CODE_W-1:0]          wr_code,
  input  logic [$clog2(GLYPH_H)-1:0] wr_row,
  input  logic [GLYPH_W-1:0]         wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [CODE_W-1:0]          req_code,
  input  logic [SCALE_W-1:0]         req_scale,
  input  logic                       req_inverse,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_data,
  output logic                       pix_last_col,
  output logic                       pix_last,
  output logic                       busy
);

  localparam int unsigned ROW_W  = $clog2(GLYPH_H);
  localparam int unsigned COL_W  = $clog2(GLYPH_W);
  localparam int unsigned ADDR_W = CODE_W + ROW_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t               state_q;
  logic [GLYPH_W-1:0]   mem [DEPTH];
  logic [GLYPH_W-1:0]   bitmap_q;
  logic [CODE_W-1:0]    code_q;
  logic [SCALE_W-1:0]   scale_q;
  logic                 inv_q;
  logic [SCALE_W-1:0]   hrep_q;
  logic [SCALE_W-1:0]   vrep_q;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;

  logic hrep_end_c;
  logic col_end_c;
  logic vrep_end_c;
  logic row_end_c;

  assign hrep_end_c = (hrep_q == scale_q);
  assign col_end_c  = (col_q == COL_W'(GLYPH_W - 1));
  assign vrep_end_c = (vrep_q == scale_q);
  assign row_end_c  = (row_q == ROW_W'(GLYPH_H - 1));

  // Font RAM: read-first, so a same-cycle write to the fetched row returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_code, wr_row}] <= wr_data;
    end
    if (state_q == FETCH) begin
      bitmap_q <= mem[{code_q, row_q}];
    end
  end

  // Control FSM; counters nest hrep -> col -> vrep -> row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      scale_q <= '0;
      inv_q   <= 1'b0;
      hrep_q  <= '0;
      vrep_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            code_q  <= req_code;
            scale_q <= req_scale;
            inv_q   <= req_inverse;
            hrep_q  <= '0;
            vrep_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          state_q <= EMIT;
        end
        EMIT: begin
          if (pix_ready) begin
            if (!hrep_end_c) begin
              hrep_q <= hrep_q + SCALE_W'(1);
            end else begin
              hrep_q <= '0;
              if (!col_end_c) begin
                col_q <= col_q + COL_W'(1);
              end else begin
                col_q <= '0;
                // Vertical repeats reuse the held bitmap; a new row needs a fetch bubble.
                if (!vrep_end_c) begin
                  vrep_q <= vrep_q + SCALE_W'(1);
                end else begin
                  vrep_q <= '0;
                  if (!row_end_c) begin
                    row_q   <= row_q + ROW_W'(1);
                    state_q <= FETCH;
                  end else begin
                    row_q   <= '0;
                    state_q <= IDLE;
                  end
                end
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; pixel fields read as zero outside EMIT.
  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign pix_valid    = (state_q == EMIT);
  assign pix_data     = pix_valid & (bitmap_q[COL_W'(GLYPH_W - 1) - col_q] ^ inv_q);
  assign pix_last_col = pix_valid & hrep_end_c & col_end_c;
  assign pix_last     = pix_last_col & vrep_end_c & row_end_c;

endmodule

// File: tb/tb_glyph_stream.sv
// Scoreboard bench for glyph_stream: stimulus pushes expected pixels, a monitor
// pops and compares on every pixel handshake.
module tb_glyph_stream;

  localparam int unsigned GW = 8;
  localparam int unsigned GH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_code;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_code;
  logic [1:0] req_scale;
  logic       req_inverse;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_data;
  logic       pix_last_col;
  logic       pix_last;
  logic       busy;

  glyph_stream dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_code      (wr_code),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_code     (req_code),
    .req_scale    (req_scale),
    .req_inverse  (req_inverse),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last_col (pix_last_col),
    .pix_last     (pix_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic lc;
    logic l;
  } pix_t;

  pix_t       exp_q[$];
  logic       cap[$];
  time        ht[$];
  logic [7:0] font [256][8];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         glyph_done;
  bit         rnd_mode = 1'b0;
  bit         stall_prev = 1'b0;
  logic [2:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Downstream readiness: always ready, or a coin flip per cycle.
  always @(posedge clk) begin
    #1;
    pix_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stall stability plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    pix_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else if (pix_valid) begin
      if (stall_prev) chk("stall_hold", 64'({pix_data, pix_last_col, pix_last}), 64'(prev_out));
      if (pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 64'({pix_data, pix_last_col, pix_last}), 64'(e));
          cap.push_back(pix_data);
          ht.push_back($time + 5);
          if (e.l) glyph_done = 1'b1;
        end
      end
      stall_prev = !pix_ready;
      prev_out   = {pix_data, pix_last_col, pix_last};
    end else begin
      if (stall_prev) chk("valid_dropped", 64'(pix_valid), 64'(1));
      stall_prev = 1'b0;
    end
  end

  task automatic write_row(input logic [7:0] code, input logic [2:0] row, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_code = code;
    wr_row  = row;
    wr_data = data;
    font[code][row] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] code, input int s, input logic inv);
    pix_t e;
    for (int r = 0; r < GH; r++)
      for (int v = 0; v < s; v++)
        for (int c = 0; c < GW; c++)
          for (int h = 0; h < s; h++) begin
            e.d  = font[code][r][GW-1-c] ^ inv;
            e.lc = (c == GW - 1) && (h == s - 1);
            e.l  = e.lc && (v == s - 1) && (r == GH - 1);
            exp_q.push_back(e);
          end
  endtask

  function automatic logic [255:0] cap_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < cap.size(); i++) v[cap.size() - 1 - i] = cap[i];
    return v;
  endfunction

  // Issue one request and wait for its final pixel; entered and left at posedge+1.
  task automatic run_glyph(input logic [7:0] code, input logic [1:0] scale, input logic inv,
                           input bit timed);
    time t_acc;
    int  n;
    int  viol;
    int  s = int'(scale) + 1;
    cap.delete();
    ht.delete();
    glyph_done = 1'b0;
    push_exp(code, s, inv);
    req_valid   = 1'b1;
    req_code    = code;
    req_scale   = scale;
    req_inverse = inv;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!rnd_mode) req_valid = 1'b0;
    req_code    = 8'hFF;
    req_scale   = 2'd3;
    req_inverse = 1'b1;
    n = 0;
    viol = 0;
    while (!glyph_done && n < 5000) begin
      @(negedge clk); #1;
      if (req_ready) viol++;
      n++;
    end
    chk("glyph_done", 64'(glyph_done), 64'(1));
    chk("no_reaccept", 64'(viol), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_last", 64'(req_ready), 64'(1));
    req_valid = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    if (timed && ht.size() > 0) begin
      chk("first_latency", 64'(ht[0] - t_acc), 64'(20));
      chk("glyph_cycles", 64'(ht[ht.size()-1] - t_acc), 64'(10 * GH * (1 + GW * s * s)));
    end
  endtask

  initial begin
    logic [255:0] v;
    logic [63:0]  ref1;
    int           n;
    for (int c = 0; c < 256; c++)
      for (int r = 0; r < 8; r++) font[c][r] = 8'h00;
    rst = 1'b1; wr_en = 1'b0; wr_code = '0; wr_row = '0; wr_data = '0;
    req_valid = 1'b0; req_code = '0; req_scale = '0; req_inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_pix_data", 64'(pix_data), 64'(0));
    chk("rst_pix_last_col", 64'(pix_last_col), 64'(0));
    chk("rst_pix_last", 64'(pix_last), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    write_row(8'h16, 3'd0, 8'h18);
    write_row(8'h16, 3'd1, 8'h18);
    write_row(8'h16, 3'd2, 8'h38);
    write_row(8'h16, 3'd3, 8'h18);
    write_row(8'h16, 3'd4, 8'h18);
    write_row(8'h16, 3'd5, 8'h18);
    write_row(8'h16, 3'd6, 8'h7E);
    write_row(8'h16, 3'd7, 8'h00);

    // Plain render.
    run_glyph(8'h16, 2'd0, 1'b0, 1'b1);
    v = cap_vec();
    chk("s1_count", 64'(cap.size()), 64'(64));
    chk("s1_first8", 64'(v[63:56]), 64'(8'b00011000));
    chk("s1_px48_55", 64'(v[15:8]), 64'(8'b01111110));
    chk("s1_last8", 64'(v[7:0]), 64'(8'h00));
    ref1 = v[63:0];

    // Scale 2.
    run_glyph(8'h16, 2'd1, 1'b0, 1'b1);
    v = cap_vec();
    chk("s2_count", 64'(cap.size()), 64'(256));
    chk("s2_line0", 64'(v[255:240]), 64'(16'b0000001111000000));
    chk("s2_line1", 64'(v[239:224]), 64'(16'b0000001111000000));
    if (ht.size() >= 33) begin
      chk("s2_no_bubble", 64'(ht[16] - ht[15]), 64'(10));
      chk("s2_one_bubble", 64'(ht[32] - ht[31]), 64'(20));
    end else begin
      chk("s2_handshakes", 64'(ht.size()), 64'(256));
    end

    // Inverse.
    run_glyph(8'h16, 2'd0, 1'b1, 1'b1);
    v = cap_vec();
    chk("inv_first8", 64'(v[63:56]), 64'(8'b11100111));
    chk("inv_last8", 64'(v[7:0]), 64'(8'hFF));

    // Random backpressure with req_valid held high.
    rnd_mode = 1'b1;
    run_glyph(8'h16, 2'd0, 1'b0, 1'b0);
    rnd_mode = 1'b0;
    v = cap_vec();
    chk("stall_sequence", v[63:0], ref1);
    repeat (2) @(posedge clk);
    #1;

    // Unwritten glyph.
    run_glyph(8'h7A, 2'd0, 1'b0, 1'b1);
    v = cap_vec();
    chk("blank_count", 64'(cap.size()), 64'(64));
    chk("blank_pixels", v[63:0], 64'(0));

    // Reset during row 3, then a clean re-render.
    cap.delete();
    ht.delete();
    glyph_done = 1'b0;
    push_exp(8'h16, 1, 1'b0);
    req_valid = 1'b1; req_code = 8'h16; req_scale = 2'd0; req_inverse = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (cap.size() < 27 && n < 200) begin @(negedge clk); #1; n++; end
    chk("reached_row3", 64'(cap.size()), 64'(27));
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_pix_valid", 64'(pix_valid), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(pix_valid), 64'(0));
    run_glyph(8'h16, 2'd0, 1'b0, 1'b1);
    v = cap_vec();
    chk("post_rst_render", v[63:0], ref1);

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
